// File: rtl/mist_spi_host_if.sv
// Command/response and SPI pin bundle for mist_spi_host.
//   master : the SPI host (takes commands, drives SPI_SCK/SPI_SS_IO/SPI_MOSI)
//   slave  : the command source plus user_io side (drives commands and SPI_MISO)
// Signals: cmd_valid/cmd_ready/cmd_code/cmd_len/cmd_data  command handshake
//          rsp_valid/rsp_data                              captured MISO bytes
//          busy                                            transaction in flight
//          SPI_SCK/SPI_SS_IO/SPI_MOSI/SPI_MISO             serial link (mode 0)
interface mist_spi_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        SPI_SCK;
  logic        SPI_SS_IO;
  logic        SPI_MOSI;
  logic        SPI_MISO;

  modport master (
    input  cmd_valid, cmd_code, cmd_len, cmd_data, SPI_MISO,
    output cmd_ready, rsp_valid, rsp_data, busy, SPI_SCK, SPI_SS_IO, SPI_MOSI
  );

  modport slave (
    output cmd_valid, cmd_code, cmd_len, cmd_data, SPI_MISO,
    input  cmd_ready, rsp_valid, rsp_data, busy, SPI_SCK, SPI_SS_IO, SPI_MOSI
  );
endinterface

// File: rtl/mist_spi_host.sv
// SPI mode-0 host emulating the MiST/SiDi I/O controller side of the user_io
// command link. One transaction = command byte + 0..MAX_LEN payload bytes,
// MSB first, chip select held low across all bytes.
// Ports:
//   Clk    system clock
//   Rst_n  asynchronous active-low reset
//   bus    mist_spi_host_if.master (command handshake, response, SPI pins)
// Parameters:
//   CLK_DIV  SPI_SCK half-period in Clk cycles (2..255)
//   MAX_LEN  payload byte limit; larger cmd_len is clamped (must be <= 7)
// Optional feature macro: SPI_HOST_MISO_CAPTURE_EN
//   defined   -> MISO bytes captured, rsp_valid pulses once per byte
//   undefined -> SPI_MISO ignored, rsp_valid/rsp_data tied to 0
module mist_spi_host #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 4
) (
  input logic             Clk,
  input logic             Rst_n,
  mist_spi_host_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StTail, StHold} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [2:0] MaxLen  = 3'(MAX_LEN);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        hold_ph_q, hold_ph_d;  // HOLD spans two divider periods
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [2:0]  len_q, len_d;
  logic [7:0]  tx_q, tx_d;            // current byte, MSB on MOSI
  logic [31:0] data_q, data_d;        // remaining payload, next byte in [7:0]
  logic [2:0]  len_clamped;
  logic        div_done;

  assign len_clamped = (bus.cmd_len > MaxLen) ? MaxLen : bus.cmd_len;
  assign div_done    = (div_q == 8'd0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      div_q     <= 8'd0;
      hold_ph_q <= 1'b0;
      bit_q     <= 3'd0;
      byte_q    <= 3'd0;
      len_q     <= 3'd0;
      tx_q      <= 8'd0;
      data_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      hold_ph_q <= hold_ph_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      len_q     <= len_d;
      tx_q      <= tx_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    hold_ph_d = hold_ph_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    len_d     = len_q;
    tx_d      = tx_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          state_d   = StSetup;
          div_d     = DivLast;
          hold_ph_d = 1'b0;
          bit_d     = 3'd7;
          byte_d    = 3'd0;
          len_d     = len_clamped;
          tx_d      = bus.cmd_code;
          data_d    = bus.cmd_data;
        end
      end
      StSetup, StLow, StTail: begin
        if (div_done) begin
          div_d = DivLast;
          unique case (state_q)
            StSetup: state_d = StLow;
            StLow:   state_d = StHigh;
            default: state_d = StHold;
          endcase
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      StHigh: begin
        if (div_done) begin
          div_d = DivLast;
          if (bit_q == 3'd0) begin
            if (byte_q == len_q) begin
              state_d = StTail;
            end else begin
              // Next byte follows immediately; no gap on SCK.
              state_d = StLow;
              byte_d  = byte_q + 3'd1;
              bit_d   = 3'd7;
              tx_d    = data_q[7:0];
              data_d  = {8'h00, data_q[31:8]};
            end
          end else begin
            state_d = StLow;
            bit_d   = bit_q - 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      StHold: begin
        if (div_done) begin
          div_d     = DivLast;
          hold_ph_d = ~hold_ph_q;
          if (hold_ph_q) state_d = StIdle;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from registered state so an asynchronous reset
  // returns the pins to idle in the same cycle.
  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.SPI_SCK   = (state_q == StHigh);
  assign bus.SPI_SS_IO = !(state_q inside {StSetup, StLow, StHigh, StTail});
  // tx_q only shifts on HIGH->LOW, so MOSI is stable whenever SCK is high.
  assign bus.SPI_MOSI  = (state_q inside {StSetup, StLow, StHigh}) ? tx_q[7] : 1'b0;

`ifdef SPI_HOST_MISO_CAPTURE_EN
  logic [7:0] rx_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       sample;

  // First HIGH cycle is the one right after the divider reload.
  assign sample = (state_q == StHigh) && (div_q == DivLast);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_q        <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
    end else begin
      rsp_valid_q <= sample && (bit_q == 3'd0);
      if (sample) rx_q <= {rx_q[6:0], bus.SPI_MISO};
      if (sample && (bit_q == 3'd0)) rsp_data_q <= {rx_q[6:0], bus.SPI_MISO};
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`else
  assign bus.rsp_valid = 1'b0;
  assign bus.rsp_data  = 8'd0;
`endif

endmodule

// File: tb/tb_mist_spi_host.sv
// Self-checking bench for mist_spi_host: directed and random commands, decoded
// from the SPI pins by a pin-level monitor and compared with byte lists built
// from the command fields.
module tb_mist_spi_host;
  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 4;

  logic Clk;
  logic Rst_n;
  mist_spi_host_if bus ();

  mist_spi_host #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // user_io MISO model: mode 0, next bit presented on each falling SCK.
  logic [7:0] miso_mem [8];
  int unsigned fall_cnt = 0;
  int unsigned fall_base = 0;
  int unsigned mi;
  always @(negedge bus.SPI_SCK) fall_cnt++;
  always @(negedge bus.SPI_SS_IO) fall_base = fall_cnt;
  always_comb begin
    mi = fall_cnt - fall_base;
    bus.SPI_MISO = (mi < 64) ? miso_mem[mi[5:3]][3'd7 - mi[2:0]] : 1'b0;
  end

  // Pin monitor, sampled on the falling Clk edge.
  logic rx_bits [$];
  logic [7:0] rsp_q [$];
  int gaps [$];
  int sck_rises = 0, ss_falls = 0, ss_rises = 0, mosi_glitch = 0, accepts = 0;
  int gap_cnt = 0;
  logic prev_sck = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0;
  always @(negedge Clk) begin
    if (bus.SPI_SCK && !prev_sck) begin
      rx_bits.push_back(bus.SPI_MOSI);
      sck_rises++;
    end
    if (bus.SPI_SCK && prev_sck && (bus.SPI_MOSI !== prev_mosi)) mosi_glitch++;
    if (!bus.SPI_SS_IO && prev_ss) begin
      ss_falls++;
      gaps.push_back(gap_cnt);
    end
    if (bus.SPI_SS_IO && !prev_ss) ss_rises++;
    if (bus.SPI_SS_IO) gap_cnt++;
    else gap_cnt = 0;
    if (bus.rsp_valid) rsp_q.push_back(bus.rsp_data);
    if (bus.cmd_valid && bus.cmd_ready) accepts++;
    prev_sck  = bus.SPI_SCK;
    prev_ss   = bus.SPI_SS_IO;
    prev_mosi = bus.SPI_MOSI;
  end

  task automatic clear_monitor();
    rx_bits.delete();
    rsp_q.delete();
    gaps.delete();
    sck_rises = 0; ss_falls = 0; ss_rises = 0; mosi_glitch = 0; accepts = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(posedge Clk); #1;
    while (!bus.cmd_ready && t < 10000) begin
      @(posedge Clk); #1;
      t++;
    end
    check("idle_wait", bus.cmd_ready, 1'b1);
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] code, input logic [31:0] data,
                                          input int k);
    logic [31:0] sh;
    if (k == 0) return code;
    sh = data >> (8 * (k - 1));
    return sh[7:0];
  endfunction

  function automatic logic [7:0] got_byte(input int k);
    logic [7:0] b = 8'hxx;
    if (rx_bits.size() >= 8 * (k + 1))
      for (int i = 0; i < 8; i++) b[7 - i] = rx_bits[8 * k + i];
    return b;
  endfunction

  task automatic run_cmd(input logic [7:0] code, input logic [2:0] len, input logic [31:0] data);
    int n, lat;
    n = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
    for (int i = 0; i < 8; i++) miso_mem[i] = 8'($urandom);
    wait_idle();
    clear_monitor();
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    @(posedge Clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 8'($urandom);
    bus.cmd_data  = $urandom;
    check("busy_after_accept", {bus.busy, bus.cmd_ready}, 2'b10);
    lat = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
    end while (!bus.cmd_ready && lat < 5000);
    check("latency", lat, CLK_DIV * (1 + 16 * (n + 1) + 1 + 2));
    check("bit_count", rx_bits.size(), 8 * (n + 1));
    for (int k = 0; k <= n; k++) check("mosi_byte", got_byte(k), exp_byte(code, data, k));
    check("ss_single_low", {ss_falls[7:0], ss_rises[7:0]}, 16'h0101);
    check("mosi_stable_sck_high", mosi_glitch, 0);
`ifdef SPI_HOST_MISO_CAPTURE_EN
    check("rsp_count", rsp_q.size(), n + 1);
    for (int k = 0; k <= n; k++)
      if (k < rsp_q.size()) check("rsp_byte", rsp_q[k], miso_mem[k]);
`else
    check("rsp_count_off", rsp_q.size(), 0);
    check("rsp_data_off", bus.rsp_data, 8'h00);
`endif
  endtask

  int t;
  int n_rsp;

  initial begin
    Rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 8'h00;
    bus.cmd_len   = 3'd0;
    bus.cmd_data  = 32'h0;
    for (int i = 0; i < 8; i++) miso_mem[i] = 8'h00;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    check("rst_ss", bus.SPI_SS_IO, 1'b1);
    check("rst_sck", bus.SPI_SCK, 1'b0);
    check("rst_mosi", bus.SPI_MOSI, 1'b0);
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rsp", {rsp_q.size() == 0, bus.rsp_valid, bus.rsp_data}, {1'b1, 1'b0, 8'h00});

    // Directed commands.
    run_cmd(8'h02, 3'd1, 32'h0000_00A5);
    run_cmd(8'h1E, 3'd4, 32'h1234_5678);
    miso_mem[0] = 8'h3C;
    run_cmd(8'h14, 3'd1, $urandom);
    run_cmd(8'h05, 3'd0, $urandom);
    run_cmd(8'h1E, 3'd7, 32'hDEAD_BEEF);  // clamped to 4 payload bytes

    // Random commands across the whole cmd_len range.
    for (int r = 0; r < 6; r++) run_cmd(8'($urandom), 3'($urandom_range(0, 7)), $urandom);

    // Back-to-back: cmd_valid held across three transactions.
    wait_idle();
    clear_monitor();
    bus.cmd_code  = 8'($urandom);
    bus.cmd_len   = 3'd1;
    bus.cmd_data  = $urandom;
    bus.cmd_valid = 1'b1;
    t = 0;
    while (accepts < 3 && t < 5000) begin
      @(posedge Clk); #1;
      t++;
    end
    bus.cmd_valid = 1'b0;
    wait_idle();
    repeat (10) @(posedge Clk);
    #1;
    check("b2b_accepts", accepts, 3);
    check("b2b_ss_falls", ss_falls, 3);
    check("b2b_sck_rises", sck_rises, 3 * 16);
    // SS high spans HOLD plus the single IDLE cycle in which the next command is taken.
    check("b2b_gap1", (gaps.size() > 1) ? gaps[1] : -1, 2 * CLK_DIV + 1);
    check("b2b_gap2", (gaps.size() > 2) ? gaps[2] : -1, 2 * CLK_DIV + 1);

    // Reset in the middle of bit 3 of byte 1.
    wait_idle();
    clear_monitor();
    bus.cmd_code  = 8'($urandom);
    bus.cmd_len   = 3'd2;
    bus.cmd_data  = $urandom;
    bus.cmd_valid = 1'b1;
    @(posedge Clk); #1;
    bus.cmd_valid = 1'b0;
    t = 0;
    while (sck_rises < 13 && t < 2000) begin
      @(posedge Clk); #1;
      t++;
    end
    check("rst_mid_reached", sck_rises >= 13, 1'b1);
    @(posedge Clk); #2;
    n_rsp = rsp_q.size();
    Rst_n = 1'b0;
    #1;
    check("rst_mid_ss", bus.SPI_SS_IO, 1'b1);
    check("rst_mid_sck", bus.SPI_SCK, 1'b0);
    check("rst_mid_mosi", bus.SPI_MOSI, 1'b0);
    check("rst_mid_ready_busy", {bus.cmd_ready, bus.busy}, 2'b10);
    check("rst_mid_rsp", {bus.rsp_valid, bus.rsp_data}, 9'h000);
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_mid_no_rsp", rsp_q.size(), n_rsp);
    run_cmd(8'hA7, 3'd2, 32'h00C3_5A96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
